// File: rtl/ctx_sort_pkg.sv
// ctx_sort shared types and constants.
// Bin/lane widths, sentinel map value, round counter helper.
package ctx_pkg;

  localparam int RUN_BIN = 13;
  localparam int NB = RUN_BIN + 1;
  localparam int NL = 8;

  typedef logic [3:0] ql_t;
  typedef logic [2:0] lane_t;

  localparam ql_t QL_NONE = 4'd15;

  function automatic logic [2:0] rnd_inc(
    input logic [2:0] r
  );
    return (r == 3'd7) ? r : r + 3'd1;
  endfunction

endpackage

// File: rtl/ctx_sort_if.sv
// ctx_sort group input and round output bundle.
// slave is the sorter side, master the producer/observer side.
interface ctx_sort_if #(
  parameter int DW = 18
);
  import ctx_pkg::*;

  logic          i_vld;
  logic          o_rdy;
  logic          i_et;
  ql_t           i_ql  [1:NL];
  logic [DW-1:0] i_dt  [1:NL];

  logic          o_vld;
  logic          o_et;
  logic          o_last;
  logic [2:0]    o_rnd;
  logic          o_bvl [0:NB-1];
  lane_t         o_bln [0:NB-1];
  logic [DW-1:0] o_bdt [0:NB-1];
  ql_t           o_ql  [1:NL];

  modport master (
    output i_vld, i_et, i_ql, i_dt,
    input  o_rdy, o_vld, o_et, o_last,
    input  o_rnd, o_bvl, o_bln, o_bdt, o_ql
  );

  modport slave (
    input  i_vld, i_et, i_ql, i_dt,
    output o_rdy, o_vld, o_et, o_last,
    output o_rnd, o_bvl, o_bln, o_bdt, o_ql
  );

endinterface

// File: rtl/ctx_sort_arb.sv
// Per-bin lowest-pending-lane selector for ctx_sort.
// Purely combinational: one lane per bin per round.
module ctx_sort_arb
  import ctx_pkg::*;
(
  input  ql_t        ql  [1:NL],
  input  logic [1:NL] msk,
  output logic       bvl [0:NB-1],
  output lane_t      bln [0:NB-1],
  output logic [1:NL] iss
);

  // bvl doubles as the "already claimed" flag, so the lowest lane wins
  always_comb begin
    iss = '0;
    for (int b = 0; b < NB; b++) begin
      bvl[b] = 1'b0;
      bln[b] = '0;
      for (int i = 1; i <= NL; i++) begin
        if (!bvl[b] && msk[i] &&
            ql[i] == ql_t'(b)) begin
          bvl[b] = 1'b1;
          bln[b] = lane_t'(i - 1);
          iss[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ctx_sort.sv
// Forward context sort: scatters an 8-lane group into bin slots,
// serialising bin collisions over rounds with input backpressure.
module ctx_sort
  import ctx_pkg::*;
#(
  parameter int DW = 18
) (
  input logic       clk,
  input logic       rstn,
  ctx_sort_if.slave bus
);

  ql_t           p_ql [1:NL];
  logic [DW-1:0] p_dt [1:NL];
  logic [1:NL]   p_msk;
  logic [1:NL]   v_msk;
  logic [1:NL]   n_msk;
  logic [1:NL]   iss;
  logic          p_emp;
  logic          p_et;
  logic [2:0]    rnd;

  logic          pend;
  logic          rdy;
  logic          acc;
  logic          last;

  logic          bvl [0:NB-1];
  lane_t         bln [0:NB-1];
  logic [DW-1:0] bdt [0:NB-1];
  ql_t           oql [1:NL];

  ctx_sort_arb u_arb (
    .ql  (p_ql),
    .msk (p_msk),
    .bvl (bvl),
    .bln (bln),
    .iss (iss)
  );

  always_comb begin
    for (int i = 1; i <= NL; i++) begin
      v_msk[i] = bus.i_ql[i] < ql_t'(NB);
    end
  end

  // p_emp keeps an all-unused group alive for one tag-carrying round
  assign pend  = (p_msk != '0) || p_emp;
  assign n_msk = p_msk & ~iss;
  assign rdy   = (p_msk == '0) || (iss == p_msk);
  assign acc   = bus.i_vld && rdy;
  assign last  = pend && (n_msk == '0);

  assign bus.o_rdy = rdy;

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      bdt[b] = '0;
      for (int i = 1; i <= NL; i++) begin
        if (bvl[b] && bln[b] == lane_t'(i - 1)) begin
          bdt[b] = p_dt[i];
        end
      end
    end
    for (int i = 1; i <= NL; i++) begin
      oql[i] = iss[i] ? p_ql[i] : QL_NONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_msk <= '0;
      p_emp <= 1'b0;
      p_et  <= 1'b0;
      rnd   <= '0;
      for (int i = 1; i <= NL; i++) begin
        p_ql[i] <= QL_NONE;
        p_dt[i] <= '0;
      end
    end else if (acc) begin
      p_msk <= v_msk;
      p_emp <= (v_msk == '0);
      p_et  <= bus.i_et;
      rnd   <= '0;
      for (int i = 1; i <= NL; i++) begin
        p_ql[i] <= bus.i_ql[i];
        p_dt[i] <= bus.i_dt[i];
      end
    end else if (pend) begin
      p_msk <= n_msk;
      p_emp <= 1'b0;
      rnd   <= rnd_inc(rnd);
    end
  end

  // idle cycles fall out as zero: no pending lanes means no bins claimed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.o_vld  <= 1'b0;
      bus.o_et   <= 1'b0;
      bus.o_last <= 1'b0;
      bus.o_rnd  <= '0;
      for (int b = 0; b < NB; b++) begin
        bus.o_bvl[b] <= 1'b0;
        bus.o_bln[b] <= '0;
        bus.o_bdt[b] <= '0;
      end
      for (int i = 1; i <= NL; i++) begin
        bus.o_ql[i] <= QL_NONE;
      end
    end else begin
      bus.o_vld  <= pend;
      bus.o_et   <= p_et && last;
      bus.o_last <= last;
      bus.o_rnd  <= pend ? rnd : 3'd0;
      for (int b = 0; b < NB; b++) begin
        bus.o_bvl[b] <= bvl[b];
        bus.o_bln[b] <= bln[b];
        bus.o_bdt[b] <= bdt[b];
      end
      for (int i = 1; i <= NL; i++) begin
        bus.o_ql[i] <= oql[i];
      end
    end
  end

endmodule

// File: tb/tb_ctx_sort.sv
// Scoreboard bench for ctx_sort: hand-scheduled rounds queued at
// stimulus time, popped and compared by a negedge monitor.
module tb_ctx_sort;
  import ctx_pkg::*;

  localparam int DW = 18;

  typedef struct packed {
    logic [2:0]               rnd;
    logic                     last;
    logic                     et;
    logic [NB-1:0]            bvl;
    logic [NB-1:0][2:0]       bln;
    logic [NB-1:0][DW-1:0]    bdt;
    logic [NL-1:0][3:0]       ql;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ctx_sort_if #(.DW(DW)) bus ();

  ctx_sort #(.DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  exp_t q[$];
  exp_t me;
  exp_t ma;
  int n_pass = 0;
  int n_chk = 0;

  ql_t           g_ql [1:NL];
  logic [DW-1:0] g_dt [1:NL];

  task automatic chk(input string nm,
                     input logic [511:0] a,
                     input logic [511:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, a, e);
  endtask

  function automatic logic [31:0] oql_pk();
    logic [31:0] r;
    for (int i = 1; i <= NL; i++)
      r[31-4*(i-1) -: 4] = bus.o_ql[i];
    return r;
  endfunction

  function automatic logic [NB-1:0] obvl_pk();
    logic [NB-1:0] r;
    for (int b = 0; b < NB; b++) r[b] = bus.o_bvl[b];
    return r;
  endfunction

  // lane 1 is the top nibble of qs
  task automatic set_grp(input logic [31:0] qs, input int seed);
    for (int i = 1; i <= NL; i++) begin
      g_ql[i] = qs[31-4*(i-1) -: 4];
      g_dt[i] = DW'(seed * 4096 + i * 37 + 5);
    end
  endtask

  // lanes: bit 7 = lane 1 ... bit 0 = lane 8
  task automatic push(input logic [7:0] lanes, input int r,
                      input logic lst, input logic et);
    exp_t e;
    e = '0;
    e.rnd = 3'(r);
    e.last = lst;
    e.et = et;
    for (int i = 1; i <= NL; i++) begin
      e.ql[i-1] = QL_NONE;
      if (lanes[8-i]) begin
        e.ql[i-1] = g_ql[i];
        e.bvl[g_ql[i]] = 1'b1;
        e.bln[g_ql[i]] = 3'(i - 1);
        e.bdt[g_ql[i]] = g_dt[i];
      end
    end
    q.push_back(e);
  endtask

  task automatic send(input logic et, output int waits);
    logic r;
    bus.i_vld = 1'b1;
    bus.i_et = et;
    for (int i = 1; i <= NL; i++) begin
      bus.i_ql[i] = g_ql[i];
      bus.i_dt[i] = g_dt[i];
    end
    r = 1'b0;
    waits = 0;
    while (!r && waits <= 40) begin
      @(negedge clk);
      r = bus.o_rdy;
      if (!r) waits++;
    end
    if (!r) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_vld = 1'b0;
    bus.i_et = 1'b0;
    for (int i = 1; i <= NL; i++) begin
      bus.i_ql[i] = QL_NONE;
      bus.i_dt[i] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.o_vld) begin
        ma = '0;
        ma.rnd = bus.o_rnd;
        ma.last = bus.o_last;
        ma.et = bus.o_et;
        for (int b = 0; b < NB; b++) begin
          ma.bvl[b] = bus.o_bvl[b];
          ma.bln[b] = bus.o_bln[b];
          ma.bdt[b] = bus.o_bdt[b];
        end
        for (int i = 1; i <= NL; i++) ma.ql[i-1] = bus.o_ql[i];
        if (q.size() == 0) begin
          chk("unexpected_round", 1, 0);
        end else begin
          me = q.pop_front();
          chk("rnd", ma.rnd, me.rnd);
          chk("last", ma.last, me.last);
          chk("et", ma.et, me.et);
          chk("bvl", ma.bvl, me.bvl);
          chk("bln", ma.bln, me.bln);
          chk("bdt", ma.bdt, me.bdt);
          chk("ql_map", ma.ql, me.ql);
        end
      end else begin
        chk("idle_last_et", {bus.o_last, bus.o_et}, 0);
        chk("idle_bvl", obvl_pk(), 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int w;
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", bus.o_vld, 0);
    chk("rst_last", bus.o_last, 0);
    chk("rst_ql", oql_pk(), 32'hFFFF_FFFF);
    chk("rst_rnd", bus.o_rnd, 0);
    @(posedge clk);
    #2 rstn = 1'b1;
    #1 chk("rdy_after_rst", bus.o_rdy, 1);
    @(posedge clk);
    #1;

    // distinct bins
    set_grp(32'h0123_4567, 1);
    push(8'hFF, 0, 1'b1, 1'b0);
    send(1'b0, w);
    chk("g1_wait", w, 0);

    // all lanes collide on bin 5
    set_grp(32'h5555_5555, 2);
    for (int k = 0; k < 8; k++)
      push(8'h80 >> k, k, k == 7, k == 7);
    send(1'b1, w);
    chk("g2_wait", w, 0);

    // mixed: {13,13,2,15,2,14,13,0}
    set_grp(32'hDD2F_2ED0, 3);
    push(8'b1010_0001, 0, 1'b0, 1'b0);
    push(8'b0100_1000, 1, 1'b0, 1'b0);
    push(8'b0000_0010, 2, 1'b1, 1'b0);
    send(1'b0, w);
    chk("g3_wait_after_8rnd", w, 7);

    // empty group with tag
    set_grp(32'hFFFF_FFFF, 4);
    push(8'h00, 0, 1'b1, 1'b1);
    send(1'b1, w);
    chk("g4_wait_after_3rnd", w, 2);

    // streaming collision-free groups
    set_grp(32'h7654_3210, 5);
    push(8'hFF, 0, 1'b1, 1'b0);
    send(1'b0, w);
    chk("s1_wait", w, 0);
    set_grp(32'hDCBA_98FE, 6);
    push(8'hFC, 0, 1'b1, 1'b0);
    send(1'b0, w);
    chk("s2_wait", w, 0);
    set_grp(32'h0246_8ACD, 7);
    push(8'hFF, 0, 1'b1, 1'b1);
    send(1'b1, w);
    chk("s3_wait", w, 0);
    set_grp(32'h33F1_FFFF, 8);
    push(8'b1001_0000, 0, 1'b0, 1'b0);
    push(8'b0100_0000, 1, 1'b1, 1'b0);
    send(1'b0, w);
    chk("s4_wait", w, 0);
    set_grp(32'h1234_5678, 9);
    push(8'hFF, 0, 1'b1, 1'b0);
    send(1'b0, w);
    chk("s5_one_bubble", w, 1);
    idle();
    repeat (4) @(posedge clk);
    #1;

    // reset during round 2 of an 8-round group
    set_grp(32'h9999_9999, 10);
    push(8'h80, 0, 1'b0, 1'b0);
    push(8'h40, 1, 1'b0, 1'b0);
    send(1'b1, w);
    idle();
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_vld", bus.o_vld, 0);
    chk("mid_rst_last_et", {bus.o_last, bus.o_et}, 0);
    chk("mid_rst_ql", oql_pk(), 32'hFFFF_FFFF);
    chk("mid_rst_bvl", obvl_pk(), 0);
    chk("mid_rst_rdy", bus.o_rdy, 1);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    chk("mid_rst_flush", q.size(), 0);
    @(posedge clk);
    #1;

    // first group after reset restarts at round 0
    set_grp(32'h44F0_FFFF, 11);
    push(8'b1001_0000, 0, 1'b0, 1'b0);
    push(8'b0100_0000, 1, 1'b1, 1'b1);
    send(1'b1, w);
    chk("post_rst_wait", w, 0);
    idle();

    for (int n = 0; n < 100 && q.size() != 0; n++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
